uart_rx_to_axis: RTL
====================

UART_RX_TO_AXIS -- requirements
Module: uart_rx_to_axis

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100, clock frequency in MHz.
REQ-002 The block SHALL have parameter BIT_RATE, default 115200, line rate in bit/s.
REQ-003 The block SHALL have parameter BIT_PER_WORD, default 8, data bits per character, legal range 5..8.
REQ-004 The block SHALL have parameter PARITY_BIT, default 0, with encoding 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS_NUM, default 1, legal values 1 or 2.
REQ-006 aclk  in  1  sole clock; all logic rising-edge.
REQ-007 areset  in  1  reset; synchronous, active-high.
REQ-008 RX  in  1  asynchronous UART serial input, idle high.
REQ-009 tdata  out  8  received character, LSB-aligned, bits above BIT_PER_WORD-1 zero.
REQ-010 tuser  out  2  {frame_err, parity_err} qualified by tvalid.
REQ-011 tvalid  out  1  AXI-Stream valid.
REQ-012 tready  in  1  AXI-Stream ready.
REQ-013 overrun  out  1  one-cycle pulse: completed character dropped.

Function
REQ-014 RX SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-015 CPP SHALL equal CLK_FREQ*10^6/BIT_RATE (integer division), and HALF SHALL equal CPP/2; the bit-timing counter SHALL be wide enough for CPP.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-017 In IDLE, a 1->0 transition of rx_s SHALL enter START and clear the counter.
REQ-018 In START, rx_s SHALL be sampled HALF cycles after entry; if 1 (false start) the FSM SHALL return to IDLE, otherwise it SHALL go to DATA.
REQ-019 In DATA, rx_s SHALL be sampled every CPP cycles into bit index 0..BIT_PER_WORD-1, LSB first; after the last bit the FSM SHALL go to PARITY if PARITY_BIT!=0, else to STOP1.
REQ-020 In PARITY, the bit SHALL be sampled after CPP cycles; the expected value SHALL be ~^data for odd and ^data for even; a mismatch SHALL set parity_err (0 when PARITY_BIT=0).
REQ-021 In STOP1, and in STOP2 when STOP_BITS_NUM=2, each sample SHALL occur after CPP cycles; a 0 sample SHALL set frame_err.
REQ-022 After the final stop sample the FSM SHALL return to IDLE at mid-stop-bit, allowing a back-to-back start edge to be detected.
REQ-023 The output register SHALL load data and errors, and tvalid SHALL rise, on the cycle after the final stop sample.
REQ-024 tdata/tuser SHALL be held stable while tvalid=1 and tready=0; tvalid SHALL drop after the tvalid&&tready cycle unless reloaded in that same cycle.
REQ-025 A character that completes while tvalid=1 and tready=0 SHALL be discarded, the held word SHALL be kept, and overrun SHALL pulse for one cycle.
REQ-026 If completion coincides with tvalid&&tready, the new word SHALL load and tvalid SHALL stay 1 with no overrun.
REQ-027 A frame_err character SHALL still be delivered.
REQ-028 A break (RX held low) SHALL NOT cause a restart until rx_s returns high and falls again.

Reset
REQ-029 On areset, the FSM SHALL go to IDLE, counters SHALL clear, both synchronizer flops SHALL be set to 1, and tvalid, tdata, tuser and overrun SHALL be 0.
REQ-030 Reset mid-character SHALL abandon the character with no output; the next character SHALL require a fresh falling edge after reset.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum, the parity encoding constants (NONE/ODD/EVEN) and a function computing CPP from CLK_FREQ and BIT_RATE, shared with the TX side.
REQ-032 Sub-module uart_rx_sync (2-flop synchronizer, reset value 1) SHALL be the only instance; the FSM, counters and output register SHALL be inline.

Verification (CLK_FREQ=100, BIT_RATE=115200 -> CPP=868, HALF=434)
REQ-033 8N1, RX drives 0xA5, tready=1 -> one tvalid beat, tdata=0xA5, tuser=00, within 1 cycle after the mid-stop sample.
REQ-034 8O1, RX drives 0x3C with correct parity 1 -> tuser=00; same character with parity 0 -> tuser=01.
REQ-035 8N2, second stop bit driven 0 -> tdata delivered, tuser=10.
REQ-036 Low glitch of 200 cycles on idle RX -> no tvalid; FSM back in IDLE.
REQ-037 tready=0; send 0x11 then 0x22 -> tdata held at 0x11, one overrun pulse; after tready=1 exactly one beat of 0x11.
REQ-038 areset asserted mid-DATA of 0x55, then a clean 0x0F -> only 0x0F delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and bit-period math.
// The TX side imports the same package so both ends agree on timing.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2
   } uart_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Clock cycles per bit period; clock given in MHz, rate in bit/s.
   function automatic int calc_cpp(input int clk_freq_mhz, input int bit_rate);
      return (clk_freq_mhz * 1_000_000) / bit_rate;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line; resets to the idle-high level.
module uart_rx_sync (
   input  logic aclk,
   input  logic areset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // NOTE: synchronous reset -- areset is only looked at on the clock edge, so it
   // sits inside the clocked branch rather than in the sensitivity list.
   always_ff @(posedge aclk) begin
      if (areset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx_to_axis.sv
// UART receiver presenting each character as a single AXI-Stream beat, with
// frame/parity status on tuser and an overrun pulse when a held word blocks delivery.
module uart_rx_to_axis
   import uart_pkg::*;
#(
   parameter int CLK_FREQ      = 100,
   parameter int BIT_RATE      = 115200,
   parameter int BIT_PER_WORD  = 8,
   parameter int PARITY_BIT    = 0,
   parameter int STOP_BITS_NUM = 1
) (
   input  logic       aclk,
   input  logic       areset,
   input  logic       RX,
   output logic [7:0] tdata,
   output logic [1:0] tuser,
   output logic       tvalid,
   input  logic       tready,
   output logic       overrun
);

   localparam int CPP   = calc_cpp(CLK_FREQ, BIT_RATE);
   localparam int HALF  = CPP / 2;
   localparam int CNT_W = $clog2(CPP + 1);

   logic rx_s;

   uart_rx_sync u_sync (
      .aclk   (aclk),
      .areset (areset),
      .d      (RX),
      .q      (rx_s)
   );

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       data_q, data_d;
   logic             frame_err_q, frame_err_d;
   logic             parity_err_q, parity_err_d;
   logic             rx_prev_q, rx_prev_d;
   logic             done;

   logic [7:0]       tdata_q, tdata_d;
   logic [1:0]       tuser_q, tuser_d;
   logic             tvalid_q, tvalid_d;
   logic             overrun_q, overrun_d;

   logic cnt_full;
   logic cnt_half;
   assign cnt_full = (cnt_q == CNT_W'(CPP - 1));
   assign cnt_half = (cnt_q == CNT_W'(HALF - 1));

   // NOTE: every signal written here gets its hold value first; a path that
   // skipped an assignment would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      data_d       = data_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      rx_prev_d    = rx_s;
      done         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Edge, not level: a held-low break cannot retrigger the receiver.
            if (rx_prev_q && !rx_s) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_half) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d      = ST_DATA;
                  bit_idx_d    = '0;
                  data_d       = '0;
                  frame_err_d  = 1'b0;
                  parity_err_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_full) begin
               cnt_d               = '0;
               data_d[bit_idx_q]   = rx_s;
               if (bit_idx_q == 3'(BIT_PER_WORD - 1)) begin
                  state_d = (PARITY_BIT != PARITY_NONE) ? ST_PARITY : ST_STOP1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PARITY: begin
            if (cnt_full) begin
               cnt_d        = '0;
               parity_err_d = (PARITY_BIT == PARITY_ODD) ? (rx_s != ~^data_q)
                                                         : (rx_s != ^data_q);
               state_d      = ST_STOP1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP1, ST_STOP2: begin
            if (cnt_full) begin
               cnt_d       = '0;
               frame_err_d = frame_err_q | ~rx_s;
               if (state_q == ST_STOP1 && STOP_BITS_NUM == 2) begin
                  state_d = ST_STOP2;
               end else begin
                  state_d = ST_IDLE;
                  done    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output holding register: a finished character may replace the held word only
   // if that word is absent or being accepted this very cycle.
   always_comb begin
      tdata_d   = tdata_q;
      tuser_d   = tuser_q;
      tvalid_d  = tvalid_q;
      overrun_d = 1'b0;
      if (done) begin
         if (!tvalid_q || tready) begin
            tdata_d  = data_q;
            tuser_d  = {frame_err_d, parity_err_d};
            tvalid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (tvalid_q && tready) begin
         tvalid_d = 1'b0;
      end
   end

   // NOTE: non-blocking assignments for all state so every flop samples the
   // pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         data_q       <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         rx_prev_q    <= 1'b1;
         tdata_q      <= '0;
         tuser_q      <= '0;
         tvalid_q     <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         data_q       <= data_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         rx_prev_q    <= rx_prev_d;
         tdata_q      <= tdata_d;
         tuser_q      <= tuser_d;
         tvalid_q     <= tvalid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign tdata   = tdata_q;
   assign tuser   = tuser_q;
   assign tvalid  = tvalid_q;
   assign overrun = overrun_q;

endmodule
